// File: rtl/sap_cpu_core_pkg.sv
// Shared definitions for the SAP accumulator core: opcodes and sequencer states.
package sap_cpu_core_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_F0   = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_X0   = 3'd3,
        ST_X1   = 3'd4,
        ST_X2   = 3'd5,
        ST_OW   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    // Instructions that take a memory operand go through X1 after decode.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/sap_cpu_core_if.sv
// Memory bus and output port of the SAP core, bundled as one interface.
// Output handshake: a word moves on every rising edge where out_valid && out_ready;
// out_valid and out_data stay stable until that edge and out_valid never waits on out_ready.
interface sap_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr, mem_wdata, mem_we, out_data, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, out_data, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/sap_cpu_core_alu.sv
// Combinational add/subtract for the accumulator; carry means "no borrow" on subtract.
module sap_cpu_core_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;

    // Subtract as a + ~b + 1 so the carry out is set exactly when a >= b.
    assign w_b      = i_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_sub};
    assign o_result = w_sum[DATA_W-1:0];
    assign o_carry  = w_sum[DATA_W];
    assign o_zero   = (w_sum[DATA_W-1:0] == '0);
endmodule

// File: rtl/sap_cpu_core.sv
// Parametrised SAP accumulator CPU: microcode FSM, C/Z flags, external sync-read memory
// and a stalling valid/ready output port. DATA_W must be at least 4 + ADDR_W.
module sap_cpu_core
    import sap_cpu_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    sap_cpu_core_if.master    bus,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        flags,
    output state_t            dbg_state
);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_c;
    logic              r_z;
    logic              w_mem_we;
    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_z;
    logic              w_sub;

    assign w_opcode  = r_ir[DATA_W-1 -: 4];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_sub     = (w_opcode == OP_SUB);

    sap_cpu_core_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (bus.mem_rdata),
        .i_sub    (w_sub),
        .o_result (w_alu_res),
        .o_carry  (w_alu_c),
        .o_zero   (w_alu_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_F0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_mem_we = 1'b0;
        case (r_state)
            ST_F0: w_next = ST_F1;
            ST_F1: w_next = ST_F2;
            ST_F2: w_next = ST_X0;
            ST_X0: begin
                if (is_mem_op(w_opcode)) begin
                    w_next = ST_X1;
                end else if (w_opcode == OP_OUT) begin
                    w_next = ST_OW;
                end else if (w_opcode == OP_HLT) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_F0;
                end
            end
            ST_X1: begin
                if (w_opcode == OP_STA) begin
                    w_mem_we = 1'b1;
                    w_next   = ST_F0;
                end else begin
                    w_next = ST_X2;
                end
            end
            ST_X2:   w_next = ST_F0;
            ST_OW:   if (bus.out_ready) w_next = ST_F0;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_F0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_F0: r_mar <= r_pc;
                ST_F2: begin
                    r_ir <= bus.mem_rdata;
                    r_pc <= r_pc + ADDR_W'(1);
                end
                ST_X0: begin
                    case (w_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_operand;
                        OP_LDI: r_a  <= {{(DATA_W-ADDR_W){1'b0}}, w_operand};
                        OP_JMP: r_pc <= w_operand;
                        OP_JC:  if (r_c) r_pc <= w_operand;
                        OP_JZ:  if (r_z) r_pc <= w_operand;
                        OP_OUT: begin
                            r_out_data  <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_X2: begin
                    // LDA leaves the flags alone; only the arithmetic ops touch C and Z.
                    if (w_opcode == OP_LDA) begin
                        r_a <= bus.mem_rdata;
                    end else begin
                        r_a <= w_alu_res;
                        r_c <= w_alu_c;
                        r_z <= w_alu_z;
                    end
                end
                ST_OW: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_mar;
    assign bus.mem_wdata = r_a;
    assign bus.mem_we    = w_mem_we;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign halted        = (r_state == ST_HALT);
    assign pc            = r_pc;
    assign flags         = {r_c, r_z};
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed programs for the SAP core with a 1-cycle RAM model and an output scoreboard.
module tb_sap_cpu_core;
    import sap_cpu_core_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        flags;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int n_we   = 0;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;

    sap_cpu_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sap_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .halted    (halted),
        .pc        (pc),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            n_we++;
        end
    end

    // Output monitor: every accepted word is checked against the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            n_out++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected actual=%0h required=none", bus.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL out_data actual=%0h required=%0h", bus.out_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_test();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        n_out = 0;
        n_we  = 0;
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int k;
        k = 0;
        while (halted !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        step(2);
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_flags", flags, 0);
        check("rst_mem_addr", bus.mem_addr, 0);

        // Reset during the X2 of a second ADD, with C set by the first.
        begin_test();
        mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h2F; mem[3] = 8'hF0;
        mem[14] = 8'd200; mem[15] = 8'd100;
        release_rst();
        step(12);
        check("t1_flags_pre", flags, 2'b10);
        check("t1_pc_pre", pc, 2);
        step(5);
        check("t1_pc_x2", pc, 3);
        rst = 1'b0;
        #1;
        check("t1_rst_pc", pc, 0);
        check("t1_rst_out_valid", bus.out_valid, 0);
        check("t1_rst_mem_we", bus.mem_we, 0);
        check("t1_rst_halted", halted, 0);
        check("t1_rst_flags", flags, 0);
        release_rst();
        step(1);
        check("t1_fetch_addr", bus.mem_addr, 0);
        step(2);
        check("t1_pc_after_fetch", pc, 1);

        // LDA 14; ADD 15; OUT; HLT -> 28 + 14 = 42
        begin_test();
        mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'hE0; mem[3] = 8'hF0;
        mem[14] = 8'd28; mem[15] = 8'd14;
        exp_q.push_back(8'h2A);
        release_rst();
        step(20);
        check("t2_not_halted", halted, 0);
        step(1);
        check("t2_halted", halted, 1);
        check("t2_pc", pc, 4);
        check("t2_flags", flags, 2'b00);
        check("t2_n_out", n_out, 1);

        // LDI 7; SUB 15 (7); JZ 9; OUT at 9
        begin_test();
        mem[0] = 8'h57; mem[1] = 8'h3F; mem[2] = 8'h89;
        mem[9] = 8'hE0; mem[10] = 8'hF0; mem[15] = 8'd7;
        exp_q.push_back(8'h00);
        release_rst();
        step(10);
        check("t3_flags", flags, 2'b11);
        step(4);
        check("t3_pc_jz", pc, 9);
        wait_halt(20, "t3_halt");
        check("t3_pc_end", pc, 11);
        check("t3_n_out", n_out, 1);

        // 200 + 100 overflows: A=44, C=1, JC taken
        begin_test();
        mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h7C; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[12] = 8'hE0; mem[13] = 8'hF0; mem[14] = 8'd200; mem[15] = 8'd100;
        exp_q.push_back(8'd44);
        release_rst();
        step(12);
        check("t4a_flags", flags, 2'b10);
        step(4);
        check("t4a_pc_jc", pc, 12);
        wait_halt(20, "t4a_halt");
        check("t4a_pc_end", pc, 14);

        // 200 + 50 fits: C=0, JC falls through
        begin_test();
        mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h7C; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[12] = 8'hE0; mem[13] = 8'hF0; mem[14] = 8'd200; mem[15] = 8'd50;
        exp_q.push_back(8'd250);
        release_rst();
        step(12);
        check("t4b_flags", flags, 2'b00);
        step(4);
        check("t4b_pc_jc", pc, 3);
        wait_halt(20, "t4b_halt");
        check("t4b_pc_end", pc, 5);

        // Backpressure: OUT held for 10 cycles, then one ready cycle
        begin_test();
        mem[0] = 8'h55; mem[1] = 8'hE0; mem[2] = 8'hF0;
        bus.out_ready = 1'b0;
        exp_q.push_back(8'd5);
        release_rst();
        step(8);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_valid", bus.out_valid, 1);
            check("t5_hold_data", bus.out_data, 5);
            check("t5_hold_pc", pc, 2);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("t5_valid_dropped", bus.out_valid, 0);
        check("t5_n_out", n_out, 1);
        wait_halt(20, "t5_halt");
        check("t5_pc_end", pc, 3);

        // PC wrap: JMP 14 at 0, NOPs at 14 and 15
        begin_test();
        mem[0] = 8'h6E; mem[14] = 8'h00; mem[15] = 8'h00;
        release_rst();
        step(4);
        check("t6_pc_a", pc, 14);
        step(4);
        check("t6_pc_b", pc, 15);
        step(4);
        check("t6_pc_c", pc, 0);
        step(4);
        check("t6_pc_d", pc, 14);
        check("t6_no_we", n_we, 0);

        // LDI 9; STA 13; LDA 13; OUT; HLT
        begin_test();
        mem[0] = 8'h59; mem[1] = 8'h4D; mem[2] = 8'h1D; mem[3] = 8'hE0; mem[4] = 8'hF0;
        exp_q.push_back(8'd9);
        release_rst();
        wait_halt(40, "t7_halt");
        check("t7_mem13", mem[13], 9);
        check("t7_n_we", n_we, 1);
        check("t7_pc_end", pc, 5);

        step(2);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
